// File: rtl/adpll_ctrl_pkg.sv
// Shared types and helpers for the ADPLL lock sequencer.
// Holds the FSM state encoding, the gain-select codes and the error-magnitude function.
package adpll_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COARSE = 2'd1,
    FINE   = 2'd2,
    LOCKED = 2'd3
  } lock_state_t;

  localparam logic [1:0] GAIN_WIDE   = 2'd2;
  localparam logic [1:0] GAIN_MED    = 2'd1;
  localparam logic [1:0] GAIN_NARROW = 2'd0;

  // -128 has no positive 8-bit counterpart, so it saturates to 127.
  function automatic logic [7:0] err_abs(input logic signed [7:0] e);
    if (e == 8'sh80)
      return 8'd127;
    else if (e[7])
      return ~e + 8'd1;
    else
      return e;
  endfunction

endpackage

// File: rtl/adpll_lock_ctrl_consec_counter.sv
// Saturating consecutive-hit counter shared by the sample streak and the watchdog.
// reached flags the hit that brings the count up to term_count.
module consec_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit,
  input  logic             clear,
  input  logic [WIDTH-1:0] term_count,
  output logic             reached
);

  logic [WIDTH-1:0] count;

  assign reached = hit && (count == term_count - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (hit && (count != term_count))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/adpll_lock_ctrl.sv
// ADPLL acquisition/lock sequencer: steps loop gain wide -> medium -> narrow and reports lock.
// Optional acquisition watchdog compiled in with ADPLL_LOCK_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | loop disabled, DCO held, wide gain
// COARSE | wide-gain acquisition, waiting for coarse-settled streak
// FINE   | medium gain, waiting for locked streak
// LOCKED | narrow gain, watching for loss-of-lock streak
module adpll_lock_ctrl
  import adpll_ctrl_pkg::*;
#(
  parameter int COARSE_THRESH   = 32,
  parameter int COARSE_COUNT    = 4,
  parameter int LOCK_THRESH     = 4,
  parameter int LOCK_COUNT      = 16,
  parameter int UNLOCK_THRESH   = 16,
  parameter int UNLOCK_COUNT    = 4,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic       fpga_clk_i,
  input  logic       reset_n_i,
  input  logic       enable_i,
  input  logic [7:0] error_i,
  input  logic       error_valid_i,
  output logic [1:0] gain_sel_o,
  output logic       hold_o,
  output logic       locked_o,
  output logic [1:0] state_o,
  output logic       timeout_o
);

  localparam int MAX_CNT_A = (COARSE_COUNT > LOCK_COUNT) ? COARSE_COUNT : LOCK_COUNT;
  localparam int MAX_CNT   = (MAX_CNT_A > UNLOCK_COUNT) ? MAX_CNT_A : UNLOCK_COUNT;
  localparam int CNT_W     = $clog2(MAX_CNT + 1);

  localparam logic [7:0] C_TH = 8'(COARSE_THRESH);
  localparam logic [7:0] L_TH = 8'(LOCK_THRESH);
  localparam logic [7:0] U_TH = 8'(UNLOCK_THRESH);

  lock_state_t      state, state_nxt;
  logic [7:0]       mag;
  logic             cnt_hit, cnt_fail, cnt_clear, cnt_reached;
  logic [CNT_W-1:0] cnt_tc;
  logic             wd_fire;

  assign mag = err_abs(error_i);

  always_comb begin
    cnt_hit  = 1'b0;
    cnt_fail = 1'b0;
    cnt_tc   = '0;
    case (state)
      COARSE: begin
        cnt_tc = CNT_W'(COARSE_COUNT);
        if (error_valid_i) begin
          cnt_hit  = (mag <= C_TH);
          cnt_fail = (mag >  C_TH);
        end
      end
      FINE: begin
        cnt_tc = CNT_W'(LOCK_COUNT);
        if (error_valid_i) begin
          cnt_hit  = (mag <= L_TH);
          cnt_fail = (mag >  L_TH);
        end
      end
      LOCKED: begin
        cnt_tc = CNT_W'(UNLOCK_COUNT);
        if (error_valid_i) begin
          cnt_hit  = (mag >  U_TH);
          cnt_fail = (mag <= U_TH);
        end
      end
      default: ;
    endcase
  end

  // Priority, lowest to highest: streak transitions, watchdog, disable.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = COARSE;
      COARSE:  if (cnt_reached) state_nxt = FINE;
      FINE: begin
        if (error_valid_i && (mag > C_TH))
          state_nxt = COARSE;
        else if (cnt_reached)
          state_nxt = LOCKED;
      end
      LOCKED:  if (cnt_reached) state_nxt = FINE;
      default: state_nxt = IDLE;
    endcase
    if (wd_fire)
      state_nxt = COARSE;
    if (!enable_i)
      state_nxt = IDLE;
  end

  assign cnt_clear = (state_nxt != state) | cnt_fail | wd_fire;

  consec_counter #(.WIDTH(CNT_W)) u_streak (
    .clk        (fpga_clk_i),
    .rst_n      (reset_n_i),
    .hit        (cnt_hit),
    .clear      (cnt_clear),
    .term_count (cnt_tc),
    .reached    (cnt_reached)
  );

`ifdef ADPLL_LOCK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_SAMPLES + 1);

  logic wd_hit, wd_clear, tmo_q, tmo_r;

  assign wd_hit   = enable_i & error_valid_i & ((state == COARSE) || (state == FINE));
  assign wd_clear = wd_fire | (state_nxt == IDLE) | (state_nxt == LOCKED);

  consec_counter #(.WIDTH(WD_W)) u_watchdog (
    .clk        (fpga_clk_i),
    .rst_n      (reset_n_i),
    .hit        (wd_hit),
    .clear      (wd_clear),
    .term_count (WD_W'(TIMEOUT_SAMPLES)),
    .reached    (wd_fire)
  );

  // Extra stage lines the pulse up with the state_o change it causes.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      tmo_q <= 1'b0;
      tmo_r <= 1'b0;
    end else begin
      tmo_q <= wd_fire;
      tmo_r <= tmo_q;
    end
  end

  assign timeout_o = tmo_r;
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      state_o    <= IDLE;
      gain_sel_o <= GAIN_WIDE;
      hold_o     <= 1'b1;
      locked_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      state_o  <= state;
      hold_o   <= (state == IDLE);
      locked_o <= (state == LOCKED);
      case (state)
        FINE:    gain_sel_o <= GAIN_MED;
        LOCKED:  gain_sel_o <= GAIN_NARROW;
        default: gain_sel_o <= GAIN_WIDE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Bench for adpll_lock_ctrl: directed vector table, randomized run against a sample-level
// reference model, and a watchdog sequence (behaviour depends on ADPLL_LOCK_TIMEOUT_EN).
module tb_adpll_lock_ctrl;

  logic       fpga_clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       enable_i = 1'b0;
  logic [7:0] error_i = 8'd0;
  logic       error_valid_i = 1'b0;
  logic [1:0] gain_sel_o;
  logic       hold_o;
  logic       locked_o;
  logic [1:0] state_o;
  logic       timeout_o;

  always #5 fpga_clk_i = ~fpga_clk_i;

  adpll_lock_ctrl dut (
    .fpga_clk_i    (fpga_clk_i),
    .reset_n_i     (reset_n_i),
    .enable_i      (enable_i),
    .error_i       (error_i),
    .error_valid_i (error_valid_i),
    .gain_sel_o    (gain_sel_o),
    .hold_o        (hold_o),
    .locked_o      (locked_o),
    .state_o       (state_o),
    .timeout_o     (timeout_o)
  );

`ifdef ADPLL_LOCK_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  // Model: 0 idle, 1 coarse, 2 fine, 3 locked. m_out is what the outputs should show.
  int n_cmp = 0;
  int n_bad = 0;
  int m_state = 0, m_out = 0, m_streak = 0, m_wd = 0;
  bit m_tq = 0, m_tout = 0;
  int saw_tmo = 0;
  int tmo_state = -1;

  typedef struct {
    bit rst;
    bit en;
    bit valid;
    int err;
    int exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit r, bit e, bit v, int err, int ex, int reps = 1);
    for (int i = 0; i < reps; i++) tbl.push_back('{r, e, v, err, ex});
  endfunction

  function automatic void model_edge(bit rst, bit en, bit valid, int err);
    int nxt, mag;
    bit fire;
    if (!rst) begin
      m_state = 0; m_out = 0; m_streak = 0; m_wd = 0; m_tq = 0; m_tout = 0;
      return;
    end
    m_out  = m_state;
    m_tout = m_tq;
    nxt  = m_state;
    fire = 0;
    mag  = (err < 0) ? -err : err;
    if (mag > 127) mag = 127;
    if (!en) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (valid) begin
      if (WD_EN && (m_state == 1 || m_state == 2)) begin
        m_wd++;
        if (m_wd == 1024) fire = 1;
      end
      if (fire) nxt = 1;
      else if (m_state == 1) begin
        m_streak = (mag <= 32) ? m_streak + 1 : 0;
        if (m_streak == 4) nxt = 2;
      end else if (m_state == 2) begin
        if (mag > 32) nxt = 1;
        else begin
          m_streak = (mag <= 4) ? m_streak + 1 : 0;
          if (m_streak == 16) nxt = 3;
        end
      end else begin
        m_streak = (mag > 16) ? m_streak + 1 : 0;
        if (m_streak == 4) nxt = 2;
      end
    end
    if (nxt != m_state || fire) m_streak = 0;
    if (nxt == 0 || nxt == 3 || fire) m_wd = 0;
    m_tq    = fire;
    m_state = nxt;
  endfunction

  task automatic step(bit rst, bit en, bit valid, int err, int exp_state, string tag);
    int eg;
    bit eh, el;
    reset_n_i     = rst;
    enable_i      = en;
    error_valid_i = valid;
    error_i       = 8'(err);
    @(posedge fpga_clk_i);
    model_edge(rst, en, valid, err);
    @(negedge fpga_clk_i);
    eg = (m_out <= 1) ? 2 : (m_out == 2 ? 1 : 0);
    eh = (m_out == 0);
    el = (m_out == 3);
    n_cmp++;
    if (int'(state_o) != m_out || int'(gain_sel_o) != eg || hold_o != eh ||
        locked_o != el || timeout_o != m_tout) begin
      n_bad++;
      $display("FAIL %s model: got st=%0d g=%0d h=%0d l=%0d t=%0d want st=%0d g=%0d h=%0d l=%0d t=%0d",
               tag, state_o, gain_sel_o, hold_o, locked_o, timeout_o, m_out, eg, eh, el, m_tout);
    end
    if (exp_state >= 0) begin
      n_cmp++;
      if (int'(state_o) != exp_state || int'(gain_sel_o) != ((exp_state <= 1) ? 2 : 3 - exp_state) ||
          hold_o != (exp_state == 0) || locked_o != (exp_state == 3)) begin
        n_bad++;
        $display("FAIL %s table: got st=%0d g=%0d h=%0d l=%0d want st=%0d",
                 tag, state_o, gain_sel_o, hold_o, locked_o, exp_state);
      end
    end
    if (timeout_o) begin
      saw_tmo++;
      tmo_state = int'(state_o);
    end
  endtask

  initial begin
    // reset and disable
    add(0, 0, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 2);
    // clean acquisition
    add(1, 1, 0, 0, 0);
    add(1, 1, 1, 20, 1, 4);
    add(1, 1, 1, 3, 2, 16);
    add(1, 1, 0, 0, 3);
    // loss of lock: -128 counts as 127
    add(1, 1, 1, -128, 3);
    add(1, 1, 1, 20, 3, 2);
    add(1, 1, 1, 2, 3);
    add(1, 1, 1, 17, 3, 4);
    add(1, 1, 0, 0, 2);
    // -128 in FINE exceeds the coarse threshold
    add(1, 1, 1, -128, 2);
    add(1, 1, 0, 0, 1);
    add(1, 1, 1, 20, 1, 4);
    add(1, 1, 0, 0, 2);
    // FINE fallback on -40
    add(1, 1, 1, -40, 2);
    add(1, 1, 0, 0, 1);
    add(1, 1, 1, 20, 1, 4);
    add(1, 1, 0, 0, 2);
    // streak restart: 3 x10, 5, then a full 16 needed
    add(1, 1, 1, 3, 2, 10);
    add(1, 1, 1, 5, 2);
    add(1, 1, 1, 3, 2, 16);
    add(1, 1, 0, 0, 3);
    add(1, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0);
    // enable drop on the 16th locked sample
    add(1, 1, 0, 0, 0);
    add(1, 1, 1, 20, 1, 4);
    add(1, 1, 0, 0, 2);
    add(1, 1, 1, 3, 2, 15);
    add(1, 0, 1, 3, 2);
    add(1, 0, 0, 0, 0, 2);
    // reset mid-operation with enable high
    add(1, 1, 0, 0, 0);
    add(1, 1, 1, 20, 1);
    add(0, 1, 1, 20, 0, 2);
    add(1, 0, 0, 0, 0);

    @(negedge fpga_clk_i);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].err, tbl[i].exp, $sformatf("vec%0d", i));

    for (int c = 0; c < 4000; c++) begin
      int r, err, quiet;
      quiet = ((c / 300) % 2 == 1) ? 97 : 40;
      r = int'($urandom_range(99));
      if (r < quiet) err = int'($urandom_range(8)) - 4;
      else if (r < quiet + 2) err = -128;
      else if (r < 98) err = int'($urandom_range(60)) - 30;
      else err = int'($urandom_range(255)) - 128;
      step($urandom_range(999) != 0, $urandom_range(199) != 0, $urandom_range(3) != 0,
           err, -1, $sformatf("rnd%0d", c));
    end

    // watchdog: enter FINE, then constant 10 for 1024 samples
    saw_tmo = 0;
    step(0, 0, 0, 0, 0, "wd_rst");
    step(1, 1, 0, 0, 0, "wd_en");
    for (int i = 0; i < 4; i++) step(1, 1, 1, 20, 1, "wd_coarse");
    for (int i = 0; i < 1024; i++) step(1, 1, 1, 10, -1, "wd_run");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, -1, "wd_tail");
    n_cmp++;
    if (WD_EN) begin
      if (saw_tmo != 1 || tmo_state != 1) begin
        n_bad++;
        $display("FAIL wd_pulse: got pulses=%0d state_at_pulse=%0d want pulses=1 state=1",
                 saw_tmo, tmo_state);
      end
    end else if (saw_tmo != 0) begin
      n_bad++;
      $display("FAIL wd_off: got pulses=%0d want 0", saw_tmo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adpll_lock_ctrl.md
# adpll_lock_ctrl

Acquisition and lock sequencer for the ADPLL loop. It watches the signed phase error from the phase detector once per reference period. It steps the loop filter gain from wide to medium to narrow bandwidth, freezes the DCO while disabled, and reports lock status. It sits beside `ADPLL` in the top level and drives its gain and hold inputs from the same 400 MHz FPGA clock.

## Interface
Parameters:
- `COARSE_THRESH`, 32: maximum |error| counted as a coarse-settled sample.
- `COARSE_COUNT`, 4: consecutive coarse-settled samples needed to leave COARSE.
- `LOCK_THRESH`, 4: maximum |error| counted as a locked sample.
- `LOCK_COUNT`, 16: consecutive locked samples needed to enter LOCKED.
- `UNLOCK_THRESH`, 16: an |error| above this counts as a loss-of-lock sample.
- `UNLOCK_COUNT`, 4: consecutive loss-of-lock samples needed to leave LOCKED.
- `TIMEOUT_SAMPLES`, 1024: acquisition watchdog length, in valid samples.

Ports:
- `fpga_clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: synchronous, active-low reset.
- `enable_i`, in, 1: loop enable, level-sensitive.
- `error_i`, in, 8: signed phase error, two's complement.
- `error_valid_i`, in, 1: one-cycle strobe marking a new `error_i` sample.
- `gain_sel_o`, out, 2: loop filter gain select; 2 = wide, 1 = medium, 0 = narrow.
- `hold_o`, out, 1: freezes the DCO control word when 1.
- `locked_o`, out, 1: lock indicator.
- `state_o`, out, 2: current FSM state encoding.
- `timeout_o`, out, 1: one-cycle pulse when the acquisition watchdog fires.

## Operation
- Magnitude: |error_i| is computed in 8 bits. The value -128 saturates to 127.
- A sample is processed only in a cycle where `error_valid_i` = 1.
- The consecutive-sample counter is a single saturating counter.
  - Cleared on every state change.
  - Cleared on any sample that fails the current state's condition.
- FSM states, with encoding:
  - IDLE = 0: `gain_sel_o` = 2, `hold_o` = 1, `locked_o` = 0. Leaves for COARSE when `enable_i` = 1.
  - COARSE = 1: `gain_sel_o` = 2, `hold_o` = 0. A sample with |e| ≤ `COARSE_THRESH` increments the counter. At `COARSE_COUNT`, the FSM moves to FINE.
  - FINE = 2: `gain_sel_o` = 1, `hold_o` = 0.
    - A sample with |e| ≤ `LOCK_THRESH` increments the counter. At `LOCK_COUNT`, the FSM moves to LOCKED.
    - Any sample with |e| > `COARSE_THRESH` returns the FSM to COARSE immediately.
  - LOCKED = 3: `gain_sel_o` = 0, `hold_o` = 0, `locked_o` = 1.
    - A sample with |e| > `UNLOCK_THRESH` increments the counter. At `UNLOCK_COUNT`, the FSM moves to FINE.
    - Any sample with |e| ≤ `UNLOCK_THRESH` clears the counter.
- `enable_i` = 0 in any state forces IDLE on the next edge. This has priority over every other transition.
- A sample arriving in the cycle a state is entered is evaluated under the newly entered state.

## Timing
- Reset values: state IDLE, `gain_sel_o` = 2, `hold_o` = 1, `locked_o` = 0, `state_o` = 0, `timeout_o` = 0. All counters are cleared.
- Reset asserted mid-operation returns to these values on the next edge, regardless of `enable_i`.
- All outputs are registered and decoded from the state register.
- A transition caused by a sample at edge N is visible on the outputs after edge N+1 (one cycle of latency).
- Enable to COARSE: `enable_i` rising at edge N gives `hold_o` = 0 after edge N+1.
- `locked_o` rises in the same cycle that `gain_sel_o` changes to 0, and falls in the same cycle it changes to 1.

## Configuration
- Macro: `ADPLL_LOCK_TIMEOUT_EN`.
- Defined:
  - A watchdog counts valid samples while in COARSE or FINE. It clears on entry to IDLE or LOCKED, and on any timeout.
  - When it reaches `TIMEOUT_SAMPLES`, `timeout_o` pulses for one cycle, the FSM goes to COARSE, and the sample counter clears.
  - A timeout in COARSE re-enters COARSE; both counters restart from 0.
- Undefined: no watchdog logic is compiled, and `timeout_o` is tied to 0.

## Structure
- Package `adpll_ctrl_pkg` holds:
  - the state enum `lock_state_t` (IDLE, COARSE, FINE, LOCKED);
  - the gain-select constants `GAIN_WIDE`, `GAIN_MED`, `GAIN_NARROW`;
  - a function `err_abs` that returns the saturating 8-bit magnitude.
- One sub-module, `consec_counter`: a saturating consecutive-hit counter with hit, clear and terminal-count inputs, reused for the sample counter and the watchdog.

## Test plan
- Reset and disable: hold `reset_n_i` = 0 for 4 cycles, then `enable_i` = 0. Require state 0, `gain_sel_o` = 2, `hold_o` = 1, `locked_o` = 0 throughout.
- Clean acquisition:
  - Stimulus: enable, then valid samples of 20 ×4 followed by 3 ×16.
  - Required: COARSE after 1 cycle; FINE after the 4th sample; LOCKED with `locked_o` = 1 and `gain_sel_o` = 0 one cycle after the 20th sample.
- FINE fallback and streak reset:
  - In FINE, a sample of -40 returns the FSM to COARSE.
  - A separate FINE run of 3 ×10 then 5 requires the lock count to restart from 0.
- Loss of lock in LOCKED:
  - Samples -128, 20, 20 then 2 keep the FSM in LOCKED.
  - A following 17, 17, 17, 17 moves it to FINE with `locked_o` = 0.
  - Also check that -128 is treated as magnitude 127.
- Enable priority: drop `enable_i` in the same cycle as the 16th locked sample. Require IDLE next, with `locked_o` staying 0.
- Watchdog (with `ADPLL_LOCK_TIMEOUT_EN` defined): feed a constant error of 10 for 1024 samples after entering FINE. Require a `timeout_o` pulse and state COARSE. Without the macro, require `timeout_o` to stay 0.
